// File: rtl/ppt_controller.sv
// PPT pulse-train generator: shadows the burst config on start; fire rises one cycle after run_ppt is seen high.
// No backpressure; run_ppt low aborts a burst at the next edge and a tick in that cycle is ignored.
module ppt_controller (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  clk_div,
  input  logic [15:0] period,
  input  logic [15:0] width,
  input  logic [15:0] count,
  input  logic        run_ppt,
  output logic        ppt_fire,
  output logic [15:0] count_done,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Shadow copies hold the effective (clamped) burst config for the whole burst
  logic [4:0]  div_q,     div_d;
  logic [15:0] per_eff_q, per_eff_d;
  logic [15:0] wid_eff_q, wid_eff_d;
  logic [15:0] cnt_q,     cnt_d;

  logic [31:0] presc_q,   presc_d;
  logic [15:0] tick_q,    tick_d;
  logic        fire_q,    fire_d;
  logic [15:0] cd_q,      cd_d;
  logic        done_q,    done_d;
  logic        busy_q,    busy_d;

  logic [15:0] in_per_eff;
  logic [15:0] in_wid_eff;
  logic [31:0] presc_term;
  logic        tick;
  logic [15:0] tick_inc;
  logic        width_hit;
  logic        period_end;
  logic [15:0] cd_inc;
  logic        last_period;

  assign in_per_eff  = (period < 16'd2) ? 16'd2 : period;
  assign in_wid_eff  = (width >= in_per_eff) ? (in_per_eff - 16'd1) : width;

  // 33-bit shift keeps clk_div=31 well defined (terminal = 2^32-1)
  assign presc_term  = 32'((33'd2 << div_q) - 33'd1);
  assign tick        = (presc_q == presc_term);
  assign tick_inc    = tick_q + 16'd1;
  assign width_hit   = (tick_inc == wid_eff_q);
  assign period_end  = (tick_inc == per_eff_q);
  assign cd_inc      = cd_q + 16'd1;
  assign last_period = (cnt_q != 16'd0) && (cd_inc == cnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run_ppt) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!run_ppt) begin
          state_d = S_IDLE;
        end else if (tick && period_end && last_period) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!run_ppt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    per_eff_d = per_eff_q;
    wid_eff_d = wid_eff_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    tick_d    = tick_q;
    fire_d    = fire_q;
    cd_d      = cd_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE: begin
        if (run_ppt) begin
          div_d     = clk_div;
          per_eff_d = in_per_eff;
          wid_eff_d = in_wid_eff;
          cnt_d     = count;
          presc_d   = 32'd0;
          tick_d    = 16'd0;
          cd_d      = 16'd0;
          done_d    = 1'b0;
          fire_d    = (in_wid_eff != 16'd0);
        end
      end
      S_RUN: begin
        if (!run_ppt) begin
          fire_d = 1'b0;
        end else begin
          presc_d = tick ? 32'd0 : (presc_q + 32'd1);
          if (tick) begin
            if (width_hit) begin
              fire_d = 1'b0;
            end
            if (period_end) begin
              cd_d = cd_inc;
              if (last_period) begin
                done_d = 1'b1;
                fire_d = 1'b0;
              end else begin
                // Next pulse starts on the same edge: no dead cycle between periods
                tick_d = 16'd0;
                fire_d = (wid_eff_q != 16'd0);
              end
            end else begin
              tick_d = tick_inc;
            end
          end
        end
      end
      default: begin
        fire_d = 1'b0;
      end
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q     <= 5'd0;
      per_eff_q <= 16'd2;
      wid_eff_q <= 16'd0;
      cnt_q     <= 16'd0;
      presc_q   <= 32'd0;
      tick_q    <= 16'd0;
      fire_q    <= 1'b0;
      cd_q      <= 16'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      per_eff_q <= per_eff_d;
      wid_eff_q <= wid_eff_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      fire_q    <= fire_d;
      cd_q      <= cd_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign ppt_fire   = fire_q;
  assign count_done = cd_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ppt_controller.sv
// Directed bench for ppt_controller: per-cycle comparison against a closed-form pulse-train model.
module tb_ppt_controller;

  logic        clk;
  logic        rstn;
  logic [4:0]  clk_div;
  logic [15:0] period;
  logic [15:0] width;
  logic [15:0] count;
  logic        run_ppt;
  logic        ppt_fire;
  logic [15:0] count_done;
  logic        done;
  logic        busy;

  int tests_run;
  int tests_failed;

  // Burst config the model follows, and cycles since the start edge
  int m_div;
  int m_per;
  int m_wid;
  int m_cnt;
  int cyc;

  ppt_controller dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
    .ppt_fire   (ppt_fire),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag);
    int t, pe, we, p, n;
    bit fin;
    t   = 1 << (m_div + 1);
    pe  = (m_per < 2) ? 2 : m_per;
    we  = (m_wid > pe - 1) ? pe - 1 : m_wid;
    p   = pe * t;
    n   = cyc / p;
    fin = (m_cnt != 0) && (n >= m_cnt);
    chk({tag, ".fire"},  {31'd0, ppt_fire}, (!fin && ((cyc % p) < we * t)) ? 32'd1 : 32'd0);
    chk({tag, ".cdone"}, {16'd0, count_done}, fin ? m_cnt : (n & 32'hFFFF));
    chk({tag, ".done"},  {31'd0, done}, fin ? 32'd1 : 32'd0);
    chk({tag, ".busy"},  {31'd0, busy}, fin ? 32'd0 : 32'd1);
  endtask

  task automatic start(input string tag, input int d, input int p, input int w, input int c);
    clk_div = 5'(d);
    period  = 16'(p);
    width   = 16'(w);
    count   = 16'(c);
    m_div = d; m_per = p; m_wid = w; m_cnt = c;
    run_ppt = 1'b1;
    step(1);
    cyc = 0;
    check_now(tag);
  endtask

  task automatic follow(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      cyc++;
      check_now(tag);
    end
  endtask

  task automatic check_idle(input string tag, input int exp_cd, input int exp_done);
    chk({tag, ".fire"},  {31'd0, ppt_fire}, 32'd0);
    chk({tag, ".cdone"}, {16'd0, count_done}, exp_cd);
    chk({tag, ".done"},  {31'd0, done}, exp_done);
    chk({tag, ".busy"},  {31'd0, busy}, 32'd0);
  endtask

  task automatic stop_run();
    run_ppt = 1'b0;
    step(2);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn    = 1'b0;
    clk_div = 5'd0;
    period  = 16'd0;
    width   = 16'd0;
    count   = 16'd0;
    run_ppt = 1'b0;
    step(3);
    check_idle("reset", 0, 0);
    rstn = 1'b1;
    step(2);
    check_idle("post_reset_idle", 0, 0);

    // Reset asserted mid-burst must clear everything without waiting for an edge
    start("pre_reset", 0, 4, 1, 0);
    follow("pre_reset", 9);
    #2 rstn = 1'b0;
    #1 check_idle("async_reset", 0, 0);
    run_ppt = 1'b0;
    step(2);
    rstn = 1'b1;
    step(2);
    check_idle("after_reset", 0, 0);

    // Large prescaler: 1024-cycle pulses every 2048 cycles
    start("div9", 9, 2, 1, 2);
    follow("div9", 4096 + 8);
    stop_run();

    start("short", 0, 4, 1, 3);
    follow("short", 30);
    // Holding run high in DONE must not restart
    follow("hold_done", 20);
    run_ppt = 1'b0;
    step(1);
    check_idle("done_to_idle", 3, 1);
    step(3);
    check_idle("idle_keeps", 3, 1);
    start("restart", 0, 4, 1, 3);
    follow("restart", 28);
    stop_run();

    // Continuous mode, abort once count_done has reached 5
    start("cont", 0, 2, 1, 0);
    follow("cont", 21);
    chk("cont.at5", {16'd0, count_done}, 32'd5);
    run_ppt = 1'b0;
    step(1);
    check_idle("abort", 5, 0);
    step(4);
    check_idle("abort_hold", 5, 0);

    start("clamp_w", 0, 3, 5, 2);
    follow("clamp_w", 16);
    stop_run();
    start("clamp_p0", 1, 0, 1, 3);
    follow("clamp_p0", 28);
    stop_run();
    start("w0", 0, 4, 0, 2);
    follow("w0", 20);
    stop_run();

    // Inputs changed mid-burst are ignored until the next start
    start("shadow", 0, 4, 1, 3);
    follow("shadow", 5);
    period = 16'd2;
    width  = 16'd0;
    count  = 16'd1;
    clk_div = 5'd1;
    follow("shadow", 25);
    stop_run();
    start("shadow_new", 1, 2, 0, 1);
    follow("shadow_new", 12);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ppt_controller.md
# ppt_controller

Pulse-train generator for the pulsed plasma thruster (PPT), sitting directly behind the register map. It consumes the CLK_DIV, PERIOD, WIDTH, COUNT and RUN fields and drives the thruster fire line. It reports completed-pulse count and burst completion back into the COUNT_DONE and DONE registers. All timing is in prescaled ticks derived from `clk`.

## Interface
- No parameters.
- `clk` in 1: system clock (32.768 kHz oscillator in the reference build).
- `rstn` in 1: reset, asynchronous, active-low.
- `clk_div` in 5: prescaler select; tick period = 2^(clk_div+1) clk cycles.
- `period` in 16: pulse period in ticks.
- `width` in 16: pulse high time in ticks.
- `count` in 16: pulses per burst; 0 means continuous.
- `run_ppt` in 1: level enable. Rising level starts a burst; low aborts it.
- `ppt_fire` out 1: registered fire pulse to the thruster driver.
- `count_done` out 16: pulses completed in the current or last burst.
- `done` out 1: burst finished normally.
- `busy` out 1: high while state is RUN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `ppt_fire`=0, `count_done`=0, `done`=0, `busy`=0, prescaler=0, tick counter=0.
- **IDLE with `run_ppt`=1** → RUN, on the same edge:
  - Latch clk_div, period, width and count into shadow registers. Later input changes are ignored until the next start.
  - Clear prescaler, tick counter and `count_done`; clear `done`.
  - Set `ppt_fire`=1 if effective width > 0.
- **Effective values:**
  - period_eff = max(period, 2).
  - width_eff = min(width, period_eff−1).
  - width_eff=0 → `ppt_fire` never rises, but periods are still timed and counted.
- **Prescaler** (32-bit): counts 0..2^(clk_div+1)−1 in RUN only. A tick is the cycle in which it equals its terminal value; it then wraps to 0.
- **Tick counter** (16-bit), advanced on each tick in RUN:
  - If tick_cnt+1 == width_eff: `ppt_fire`←0.
  - If tick_cnt+1 == period_eff (end of period): `count_done`←`count_done`+1.
    - If count≠0 and `count_done`+1 == count: → DONE, `done`←1, `ppt_fire` stays 0.
    - Otherwise: tick_cnt←0 and `ppt_fire`←(width_eff>0), starting the next pulse with no gap cycle.
  - Otherwise: tick_cnt←tick_cnt+1.
- **Continuous mode (count=0):** `count_done` wraps 0xFFFF→0x0000; `done` is never set.
- **RUN with `run_ppt`=0 (abort):** → IDLE next edge, `ppt_fire`←0, `done` stays 0, `count_done` holds its partial value. Abort takes priority over a tick in the same cycle.
- **DONE:** holds until `run_ppt`=0, then → IDLE. `done` and `count_done` remain valid in IDLE until the next start. A burst restarts only after `run_ppt` is seen low then high.
- Reset asserted mid-burst: all outputs and state return to reset values immediately.

## Timing
- All outputs are registered.
- Start latency: `ppt_fire` is high the cycle after the edge that samples `run_ppt`=1 in IDLE.
- Pulse high time = width_eff·2^(clk_div+1) clk cycles. Pulse period = period_eff·2^(clk_div+1) clk cycles, exact and jitter-free.
- `count_done` increments and `done` rises on the same edge as the final period end.
- `busy` falls on the edge entering DONE or IDLE.
- Abort: `ppt_fire` is low one cycle after `run_ppt` is sampled low.

## Test plan
- **Reset, default burst:** assert rstn low mid-run → all outputs 0. Then clk_div=9, period=128, width=1, count=16, run=1:
  - pulses are 1024 cycles high every 131072 cycles;
  - `done`=1 after 16 periods, with `count_done`=16.
- **Short burst:** clk_div=0, period=4, width=1, count=3, run=1:
  - `ppt_fire` high 2 cycles every 8;
  - `count_done` steps 1, 2, 3 at cycles 8, 16, 24 after start;
  - `done`=1 at cycle 24 and `busy`=0.
- **Continuous and abort:** count=0, clk_div=0, period=2, width=1. Drop run after `count_done`=5 → `ppt_fire`=0 next cycle, `count_done`=5, `done`=0, state IDLE.
- **Clamping:** period=3, width=5 → high 2 ticks, low 1 tick. period=0 → behaves as 2. width=0 → `ppt_fire` stays 0 while `count_done` still advances.
- **Shadowing:** change period/width/count mid-burst → current burst unchanged; the new values apply only after run 1→0→1.
- **Restart:** hold run=1 in DONE → no restart. run=0 then 1 → `done` clears, `count_done` clears, and a new burst starts.
